// File: rtl/f_sequencer_pkg.sv
// Shared constants for the F permutation sequencer: FSM encoding, block size
// and domain-separation field layout.
package f_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_RUN    = 3'd3,
      ST_OUT    = 3'd4
   } f_state_e;

   localparam int DS_FINAL_BIT = 3;
   localparam int DS_CNT_LSB   = 0;
   localparam int DS_CNT_W     = 3;
   localparam int BLK_WORDS    = 4;

endpackage

// File: rtl/f_sequencer_if.sv
// Message-word and result stream handshakes between the sequencer and its
// source/sink.
interface f_sequencer_if #(
   parameter int RWIDTH = 32
);

   logic              m_valid;
   logic              m_ready;
   logic [31:0]       m_data;
   logic              m_last;
   logic              r_valid;
   logic              r_ready;
   logic [RWIDTH-1:0] r_data;
   logic              r_last;

   modport master (
      output m_valid, m_data, m_last, r_ready,
      input  m_ready, r_valid, r_data, r_last
   );

   modport slave (
      input  m_valid, m_data, m_last, r_ready,
      output m_ready, r_valid, r_data, r_last
   );

endinterface

// File: rtl/f_sequencer.sv
// Packs 32-bit message words into 128-bit blocks, launches F once per block,
// chains F's state output back into its state input and streams the results.
module f_sequencer
   import f_pkg::*;
#(
   parameter int CWIDTH      = 320,
   parameter int XWORDS32    = 9,
   parameter int DS_WIDTH    = 128,
   parameter int RWIDTH      = 32,
   parameter int ROUND_COUNT = 10,
   parameter int MAX_WAIT    = 1023
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [CWIDTH-1:0]        c_init,
   input  logic [XWORDS32*32-1:0]   key,
   input  logic [ROUND_COUNT-1:0]   rounds,
   f_sequencer_if.slave             bus,
   output logic [CWIDTH-1:0]        f_c,
   output logic [XWORDS32*32-1:0]   f_x,
   output logic [127:0]             f_i,
   output logic [DS_WIDTH-1:0]      f_ds,
   output logic [ROUND_COUNT-1:0]   f_rounds,
   output logic                     f_reset,
   input  logic [CWIDTH-1:0]        f_cout,
   input  logic [RWIDTH-1:0]        f_rout,
   input  logic                     f_done,
   output logic                     busy,
   output logic                     timeout
);

   localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] FILL   = ST_FILL;
   localparam logic [2:0] LAUNCH = ST_LAUNCH;
   localparam logic [2:0] RUN    = ST_RUN;
   localparam logic [2:0] OUT    = ST_OUT;

   logic [2:0]               st;
   logic [CWIDTH-1:0]        state_reg;
   logic [XWORDS32*32-1:0]   key_reg;
   logic [ROUND_COUNT-1:0]   rounds_reg;
   logic [127:0]             i_reg;
   logic [RWIDTH-1:0]        r_reg;
   logic [2:0]               word_cnt;
   logic                     final_flag;
   logic [WW-1:0]            wait_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st         <= IDLE;
         state_reg  <= '0;
         key_reg    <= '0;
         rounds_reg <= '0;
         i_reg      <= '0;
         r_reg      <= '0;
         word_cnt   <= '0;
         final_flag <= 1'b0;
         wait_cnt   <= '0;
         timeout    <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (start) begin
                  state_reg  <= c_init;
                  key_reg    <= key;
                  rounds_reg <= rounds;
                  i_reg      <= '0;
                  word_cnt   <= '0;
                  final_flag <= 1'b0;
                  timeout    <= 1'b0;
                  st         <= FILL;
               end
            end
            FILL: begin
               // m_ready is high throughout FILL, so m_valid alone is an accept
               if (bus.m_valid) begin
                  i_reg[{word_cnt[1:0], 5'd0} +: 32] <= bus.m_data;
                  word_cnt   <= word_cnt + 3'd1;
                  final_flag <= bus.m_last;
                  if (bus.m_last || word_cnt == 3'(BLK_WORDS - 1))
                     st <= LAUNCH;
               end
            end
            LAUNCH: begin
               wait_cnt <= '0;
               st       <= RUN;
            end
            RUN: begin
               // done takes priority over an expiring wait budget
               if (f_done) begin
                  state_reg <= f_cout;
                  r_reg     <= f_rout;
                  st        <= OUT;
               end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                  timeout <= 1'b1;
                  st      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            OUT: begin
               if (bus.r_ready) begin
                  if (final_flag) begin
                     st <= IDLE;
                  end else begin
                     i_reg    <= '0;
                     word_cnt <= '0;
                     st       <= FILL;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   always_comb begin
      f_ds = '0;
      f_ds[DS_FINAL_BIT] = final_flag;
      f_ds[DS_CNT_LSB +: DS_CNT_W] = word_cnt;
   end

   assign f_c         = state_reg;
   assign f_x         = key_reg;
   assign f_i         = i_reg;
   assign f_rounds    = rounds_reg;
   assign f_reset     = (st != RUN);
   assign busy        = (st != IDLE);
   assign bus.m_ready = (st == FILL);
   assign bus.r_valid = (st == OUT);
   assign bus.r_last  = (st == OUT) && final_flag;
   assign bus.r_data  = r_reg;

endmodule

// File: tb/tb_f_sequencer.sv
// Bench for f_sequencer: behavioural F behind the DUT, table vectors, random
// messages against a block-level reference model, and hand-written corner cases.
module tb_f_sequencer;

   localparam int CW = 320;
   localparam int XW = 9 * 32;
   localparam int MAXW = 1023;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [CW-1:0] c_init = '0;
   logic [XW-1:0] key = '0;
   logic [9:0] rounds = '0;
   logic [CW-1:0] f_c;
   logic [XW-1:0] f_x;
   logic [127:0] f_i;
   logic [127:0] f_ds;
   logic [9:0] f_rounds;
   logic f_reset;
   logic [CW-1:0] f_cout = '0;
   logic [31:0] f_rout = '0;
   logic f_done = 1'b0;
   logic busy;
   logic timeout;

   f_sequencer_if #(.RWIDTH(32)) bus ();

   f_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .c_init(c_init), .key(key),
      .rounds(rounds), .bus(bus), .f_c(f_c), .f_x(f_x), .f_i(f_i), .f_ds(f_ds),
      .f_rounds(f_rounds), .f_reset(f_reset), .f_cout(f_cout), .f_rout(f_rout),
      .f_done(f_done), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Behavioural F: an arbitrary mixing of its inputs with a random latency.
   function automatic logic [CW-1:0] f_next(logic [CW-1:0] c, logic [127:0] i,
                                            logic [7:0] ds, logic [XW-1:0] x, logic [9:0] rn);
      return {c[CW-2:0], c[CW-1]} ^ {192'd0, i} ^ {312'd0, ds} ^ {x[31:0], 288'd0} ^ {310'd0, rn};
   endfunction

   function automatic logic [31:0] f_res(logic [CW-1:0] c, logic [127:0] i,
                                         logic [7:0] ds, logic [XW-1:0] x, logic [9:0] rn);
      return c[31:0] ^ i[31:0] ^ i[63:32] ^ i[95:64] ^ i[127:96] ^ {24'd0, ds} ^ x[63:32] ^ {22'd0, rn};
   endfunction

   bit f_stub = 1'b0;
   int f_cnt = 0;
   int f_lat = 0;

   always @(posedge clk) begin
      if (f_reset) begin
         f_cnt  <= 0;
         f_done <= 1'b0;
         f_lat  <= int'($urandom_range(0, 4));
      end else if (!f_stub && !f_done) begin
         if (f_cnt >= f_lat) begin
            f_done <= 1'b1;
            f_cout <= f_next(f_c, f_i, f_ds[7:0], f_x, f_rounds);
            f_rout <= f_res(f_c, f_i, f_ds[7:0], f_x, f_rounds);
         end else begin
            f_cnt <= f_cnt + 1;
         end
      end
   end

   // Monitor: record each launch (first RUN cycle) and each result handshake.
   logic [127:0] q_i[$];
   logic [127:0] q_ds[$];
   logic [CW-1:0] q_c[$];
   logic [31:0] q_r[$];
   logic q_rl[$];
   logic prev_fr = 1'b1;

   always @(negedge clk) begin
      if (prev_fr && !f_reset) begin
         q_i.push_back(f_i);
         q_ds.push_back(f_ds);
         q_c.push_back(f_c);
      end
      prev_fr <= f_reset;
      if (bus.r_valid && bus.r_ready) begin
         q_r.push_back(bus.r_data);
         q_rl.push_back(bus.r_last);
      end
   end

   // r_ready policy: 0 = held low, 1 = held high, 2 = random.
   int rr_mode = 1;
   initial begin
      bus.r_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0: bus.r_ready = 1'b0;
            1: bus.r_ready = 1'b1;
            default: bus.r_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_i.delete(); q_ds.delete(); q_c.delete(); q_r.delete(); q_rl.delete();
   endtask

   task automatic randomize_setup();
      for (int k = 0; k < CW / 32; k++) c_init[32*k +: 32] = $urandom;
      for (int k = 0; k < XW / 32; k++) key[32*k +: 32] = $urandom;
      rounds = 10'($urandom_range(0, 1023));
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      bit acc = 1'b0;
      int n = 0;
      bus.m_valid = 1'b1;
      bus.m_data  = w;
      bus.m_last  = last;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bus.m_ready;
         tick();
         n++;
      end
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_last  = 1'b0;
      if (!acc) check("word_accept", CW'(acc), CW'(1));
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      check("return_idle", CW'(busy), CW'(0));
   endtask

   logic [31:0] msg[$];

   // Run msg through the DUT and compare every launch and result with a
   // block-level model of the message: 4-word chunks, chained state.
   task automatic run_msg(input string tag);
      int n;
      int nb;
      int cnt;
      logic [CW-1:0] st;
      logic [127:0] blk;
      logic [7:0] ds;
      logic fin;
      n = msg.size();
      clear_q();
      do_start();
      for (int k = 0; k < n; k++) send_word(msg[k], k == n - 1);
      wait_idle(5000);
      nb = (n + 3) / 4;
      st = c_init;
      check({tag, "_nlaunch"}, CW'(q_i.size()), CW'(nb));
      check({tag, "_nresult"}, CW'(q_r.size()), CW'(nb));
      for (int b = 0; b < nb; b++) begin
         cnt = (n - 4 * b > 4) ? 4 : n - 4 * b;
         blk = '0;
         for (int j = 0; j < cnt; j++) blk[32*j +: 32] = msg[4*b + j];
         fin = (b == nb - 1);
         ds = 8'(cnt) | (fin ? 8'h08 : 8'h00);
         if (b < q_i.size()) begin
            check({tag, "_f_i"}, CW'(q_i[b]), CW'(blk));
            check({tag, "_f_ds"}, CW'(q_ds[b]), CW'(ds));
            check({tag, "_f_c"}, q_c[b], st);
         end
         if (b < q_r.size()) begin
            check({tag, "_r_data"}, CW'(q_r[b]), CW'(f_res(st, blk, ds, key, rounds)));
            check({tag, "_r_last"}, CW'(q_rl[b]), CW'(fin));
         end
         st = f_next(st, blk, ds, key, rounds);
      end
   endtask

   typedef struct {
      int n;
      logic [31:0] w[6];
      int nblk;
      logic [127:0] ei[2];
      logic [7:0] eds[2];
   } vec_t;

   vec_t vec[5];

   initial begin
      bit ok;
      bit seen;
      int n;
      int runc;
      logic [31:0] hold;
      logic [CW-1:0] hc;
      logic [127:0] blk;

      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_last  = 1'b0;

      vec[0] = '{n: 4, w: '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0, 32'h0}, nblk: 1,
                 ei: '{128'h00000004_00000003_00000002_00000001, 128'h0}, eds: '{8'h0C, 8'h00}};
      vec[1] = '{n: 6, w: '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005, 32'hA0000006},
                 nblk: 2,
                 ei: '{128'hA0000004_A0000003_A0000002_A0000001, 128'h00000000_00000000_A0000006_A0000005},
                 eds: '{8'h04, 8'h0A}};
      vec[2] = '{n: 1, w: '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, nblk: 1,
                 ei: '{128'h00000000_00000000_00000000_DEADBEEF, 128'h0}, eds: '{8'h09, 8'h00}};
      vec[3] = '{n: 3, w: '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0}, nblk: 1,
                 ei: '{128'h00000000_00000033_00000022_00000011, 128'h0}, eds: '{8'h0B, 8'h00}};
      vec[4] = '{n: 5, w: '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'h0}, nblk: 2,
                 ei: '{128'h000000C4_000000C3_000000C2_000000C1, 128'h00000000_00000000_00000000_000000C5},
                 eds: '{8'h04, 8'h09}};

      // Reset state
      tick();
      tick();
      check("rst_m_ready", CW'(bus.m_ready), CW'(0));
      check("rst_r_valid", CW'(bus.r_valid), CW'(0));
      check("rst_r_last", CW'(bus.r_last), CW'(0));
      check("rst_busy", CW'(busy), CW'(0));
      check("rst_timeout", CW'(timeout), CW'(0));
      check("rst_f_reset", CW'(f_reset), CW'(1));
      check("rst_r_data", CW'(bus.r_data), CW'(0));
      check("rst_f_c", f_c, '0);
      check("rst_f_x", CW'(f_x), CW'(0));
      check("rst_f_i", CW'(f_i), CW'(0));
      check("rst_f_ds", CW'(f_ds), CW'(0));
      check("rst_f_rounds", CW'(f_rounds), CW'(0));
      reset_n = 1'b1;
      tick();

      // Table vectors
      rr_mode = 1;
      for (int v = 0; v < 5; v++) begin
         randomize_setup();
         msg.delete();
         for (int k = 0; k < vec[v].n; k++) msg.push_back(vec[v].w[k]);
         run_msg($sformatf("vec%0d", v));
         for (int b = 0; b < vec[v].nblk; b++) begin
            if (b < q_i.size()) begin
               check($sformatf("vec%0d_tbl_f_i", v), CW'(q_i[b]), CW'(vec[v].ei[b]));
               check($sformatf("vec%0d_tbl_ds", v), CW'(q_ds[b]), CW'(vec[v].eds[b]));
            end
         end
         tick();
      end

      // Random messages with random result backpressure
      rr_mode = 2;
      for (int t = 0; t < 15; t++) begin
         randomize_setup();
         msg.delete();
         n = int'($urandom_range(1, 10));
         for (int k = 0; k < n; k++) msg.push_back($urandom);
         run_msg($sformatf("rnd%0d", t));
         tick();
      end

      // r_ready held low for 50 cycles on a non-final block
      rr_mode = 0;
      randomize_setup();
      clear_q();
      do_start();
      for (int k = 0; k < 4; k++) send_word(32'h5000 + k, 1'b0);
      n = 0;
      while (!bus.r_valid && n < 100) begin
         tick();
         n++;
      end
      check("stall_r_valid", CW'(bus.r_valid), CW'(1));
      check("stall_r_last", CW'(bus.r_last), CW'(0));
      blk = {32'h5003, 32'h5002, 32'h5001, 32'h5000};
      check("stall_r_data", CW'(bus.r_data), CW'(f_res(c_init, blk, 8'h04, key, rounds)));
      hold = bus.r_data;
      hc = f_c;
      ok = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.r_data !== hold || bus.m_ready !== 1'b0 || bus.r_valid !== 1'b1 || f_c !== hc) ok = 1'b0;
      end
      check("stall_stable", CW'(ok), CW'(1));
      rr_mode = 1;
      n = 0;
      while (!bus.m_ready && n < 10) begin
         tick();
         n++;
      end
      check("stall_release_fill", CW'(bus.m_ready), CW'(1));
      check("stall_release_rvalid", CW'(bus.r_valid), CW'(0));
      check("stall_nresult", CW'(q_r.size()), CW'(1));
      send_word(32'h6000, 1'b1);
      wait_idle(200);
      check("stall_nresult2", CW'(q_r.size()), CW'(2));

      // F never finishes: timeout after the wait budget
      tick();
      f_stub = 1'b1;
      clear_q();
      do_start();
      send_word(32'h7, 1'b1);
      n = 0;
      runc = 0;
      while (!timeout && n < 3000) begin
         @(negedge clk);
         if (!f_reset) runc++;
         tick();
         n++;
      end
      check("to_timeout", CW'(timeout), CW'(1));
      check("to_run_cycles", CW'(runc), CW'(MAXW));
      check("to_busy", CW'(busy), CW'(0));
      check("to_no_result", CW'(q_r.size()), CW'(0));
      tick();
      check("to_sticky", CW'(timeout), CW'(1));
      f_stub = 1'b0;
      do_start();
      check("to_cleared_by_start", CW'(timeout), CW'(0));
      send_word(32'h8, 1'b1);
      wait_idle(200);
      check("to_after_result", CW'(q_r.size()), CW'(1));

      // Asynchronous reset while F is running
      tick();
      f_stub = 1'b1;
      clear_q();
      randomize_setup();
      do_start();
      send_word(32'h9, 1'b1);
      tick();
      check("ar_in_run", CW'(f_reset), CW'(0));
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_f_reset", CW'(f_reset), CW'(1));
      check("ar_busy", CW'(busy), CW'(0));
      check("ar_m_ready", CW'(bus.m_ready), CW'(0));
      check("ar_r_valid", CW'(bus.r_valid), CW'(0));
      check("ar_f_c", f_c, '0);
      check("ar_f_i", CW'(f_i), CW'(0));
      check("ar_f_ds", CW'(f_ds), CW'(0));
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      f_stub = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.r_valid) seen = 1'b1;
      end
      check("ar_no_result", CW'(seen), CW'(0));
      check("ar_idle", CW'(busy), CW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
